lfsr_checker: RTL and testbench



---
 rtl/lfsr_pkg.sv | 22 ++
 rtl/lfsr_checker_if.sv | 25 ++
 rtl/lfsr_step.sv | 15 +
 rtl/lfsr_checker.sv | 137 +++++++++++++
 tb/tb_lfsr_checker.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/lfsr_pkg.sv
// Shared definitions for the 4-bit LFSR generator/checker pair:
// default width and taps, checker state encoding and a reference step function.
package lfsr_pkg;

  localparam int              LFSR_WIDTH = 4;
  localparam logic [3:0]      LFSR_TAPS  = 4'b1100;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } lfsr_state_e;

  // Fixed-width step used wherever the default-width LFSR is modelled.
  function automatic logic [LFSR_WIDTH-1:0] lfsr_next(
    input logic [LFSR_WIDTH-1:0] x,
    input logic [LFSR_WIDTH-1:0] taps
  );
    return {x[LFSR_WIDTH-2:0], ^(x & taps)};
  endfunction

endpackage

// File: rtl/lfsr_checker_if.sv
// Beat/status bundle between an LFSR stream source and the checker.
// master drives the received words, slave is the checker side.
interface lfsr_checker_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);

  logic             ena;
  logic [WIDTH-1:0] din;
  logic             clr_err;
  logic             locked;
  logic             err_pulse;
  logic [CNT_W-1:0] err_count;

  modport master (
    output ena, din, clr_err,
    input  locked, err_pulse, err_count
  );

  modport slave (
    input  ena, din, clr_err,
    output locked, err_pulse, err_count
  );

endinterface

// File: rtl/lfsr_step.sv
// Combinational single-step of a Fibonacci-style LFSR: shift left, feed back
// the parity of the tapped bits into bit 0. Shared with the pattern generator.
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = LFSR_WIDTH,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(LFSR_TAPS)
) (
  input  logic [WIDTH-1:0] i_word,
  output logic [WIDTH-1:0] o_next
);

  assign o_next = {i_word[WIDTH-2:0], ^(i_word & TAPS)};

endmodule

// File: rtl/lfsr_checker.sv
// Receive-side LFSR stream checker: hunts for a seed, confirms lock, then
// flywheels its own prediction and counts mismatches.
// Optional build macro LFSR_CHK_ERR_SAT_EN makes err_count saturate instead of wrap.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int               WIDTH        = LFSR_WIDTH,
  parameter logic [WIDTH-1:0] TAPS         = WIDTH'(LFSR_TAPS),
  parameter int               LOCK_COUNT   = 3,
  parameter int               UNLOCK_COUNT = 2,
  parameter int               CNT_W        = 8
) (
  input  logic           clk,
  input  logic           rst,
  lfsr_checker_if.slave  bus
);

  localparam int             MW         = $clog2(LOCK_COUNT + 1);
  localparam int             UW         = $clog2(UNLOCK_COUNT + 1);
  localparam logic [MW-1:0]  LOCK_VAL   = MW'(LOCK_COUNT);
  localparam logic [UW-1:0]  UNLOCK_VAL = UW'(UNLOCK_COUNT);

  lfsr_state_e      r_state,    w_state;
  logic [WIDTH-1:0] r_expected, w_expected;
  logic [MW-1:0]    r_matchCnt, w_matchCnt;
  logic [UW-1:0]    r_missCnt,  w_missCnt;
  logic [CNT_W-1:0] r_errCount, w_errCount;
  logic             r_locked;
  logic             r_errPulse, w_errPulse;
  logic             w_errInc;
  logic [WIDTH-1:0] w_dinNext;
  logic [WIDTH-1:0] w_expNext;

  // Reseeding follows the received word; once locked the prediction runs on its own.
  lfsr_step #(.WIDTH(WIDTH), .TAPS(TAPS)) u_stepDin (
    .i_word (bus.din),
    .o_next (w_dinNext)
  );

  lfsr_step #(.WIDTH(WIDTH), .TAPS(TAPS)) u_stepExp (
    .i_word (r_expected),
    .o_next (w_expNext)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= HUNT;
      r_expected <= '0;
      r_matchCnt <= '0;
      r_missCnt  <= '0;
      r_errCount <= '0;
      r_locked   <= 1'b0;
      r_errPulse <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_expected <= w_expected;
      r_matchCnt <= w_matchCnt;
      r_missCnt  <= w_missCnt;
      r_errCount <= w_errCount;
      r_locked   <= (w_state == LOCKED);
      r_errPulse <= w_errPulse;
    end
  end

  always_comb begin
    w_state    = r_state;
    w_expected = r_expected;
    w_matchCnt = r_matchCnt;
    w_missCnt  = r_missCnt;
    w_errPulse = 1'b0;
    w_errInc   = 1'b0;
    if (bus.ena) begin
      case (r_state)
        HUNT: begin
          // The all-zero word is the LFSR lockup state and can never seed a sequence.
          if (bus.din != '0) begin
            w_expected = w_dinNext;
            w_matchCnt = MW'(1);
            w_state    = CHECK;
          end
        end
        CHECK: begin
          if (bus.din == r_expected) begin
            w_expected = w_dinNext;
            w_matchCnt = r_matchCnt + 1'b1;
            if (w_matchCnt == LOCK_VAL) begin
              w_state   = LOCKED;
              w_missCnt = '0;
            end
          end else if (bus.din != '0) begin
            w_expected = w_dinNext;
            w_matchCnt = MW'(1);
          end else begin
            w_state = HUNT;
          end
        end
        LOCKED: begin
          w_expected = w_expNext;
          if (bus.din == r_expected) begin
            w_missCnt = '0;
          end else begin
            w_errPulse = 1'b1;
            w_errInc   = 1'b1;
            w_missCnt  = r_missCnt + 1'b1;
            if (w_missCnt == UNLOCK_VAL) begin
              w_state = HUNT;
            end
          end
        end
        default: begin
          w_state = HUNT;
        end
      endcase
    end
  end

  // A clear wins over a same-cycle increment; the strobe is unaffected.
  always_comb begin
    w_errCount = r_errCount;
    if (bus.clr_err) begin
      w_errCount = '0;
    end else if (w_errInc) begin
`ifdef LFSR_CHK_ERR_SAT_EN
      if (!(&r_errCount)) begin
        w_errCount = r_errCount + 1'b1;
      end
`else
      w_errCount = r_errCount + 1'b1;
`endif
    end
  end

  assign bus.locked    = r_locked;
  assign bus.err_pulse = r_errPulse;
  assign bus.err_count = r_errCount;

endmodule

// File: tb/tb_lfsr_checker.sv
// Bench for lfsr_checker: a behavioural model checked every cycle against two
// DUTs (8-bit and 2-bit error counters) plus hand-computed directed expectations.
module tb_lfsr_checker;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   p;
  int   seq [15] = '{1, 2, 4, 9, 3, 6, 13, 10, 5, 11, 7, 15, 14, 12, 8};

  lfsr_checker_if #(.WIDTH(4), .CNT_W(8)) ifA ();
  lfsr_checker_if #(.WIDTH(4), .CNT_W(2)) ifB ();

  lfsr_checker #(.CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifA.slave)
  );

  lfsr_checker #(.CNT_W(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (ifB.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: mode 0 = hunting, 1 = confirming, 2 = locked.
  int mMode, mExp, mMatch, mMiss, mLocked, mPulse, mCnt8, mCnt2;

  function automatic int modelNext(input int x);
    int fb;
    fb = $countones(x & 12) % 2;
    return ((x * 2) % 16) + fb;
  endfunction

  function automatic int bump(input int c, input int modulus);
`ifdef LFSR_CHK_ERR_SAT_EN
    return (c == modulus - 1) ? c : c + 1;
`else
    return (c + 1) % modulus;
`endif
  endfunction

  always @(posedge clk or negedge rst) begin
    int  d;
    bit  err;
    if (!rst) begin
      mMode = 0; mExp = 0; mMatch = 0; mMiss = 0;
      mLocked = 0; mPulse = 0; mCnt8 = 0; mCnt2 = 0;
    end else begin
      d = int'(ifA.din);
      err = 0;
      mPulse = 0;
      if (ifA.ena) begin
        if (mMode == 0) begin
          if (d != 0) begin
            mExp = modelNext(d); mMatch = 1; mMode = 1;
          end
        end else if (mMode == 1) begin
          if (d == mExp) begin
            mExp = modelNext(d);
            mMatch = mMatch + 1;
            if (mMatch == 3) begin
              mMode = 2; mMiss = 0;
            end
          end else if (d != 0) begin
            mExp = modelNext(d); mMatch = 1;
          end else begin
            mMode = 0;
          end
        end else begin
          if (d == mExp) begin
            mMiss = 0;
          end else begin
            err = 1;
            mPulse = 1;
            mMiss = mMiss + 1;
            if (mMiss == 2) mMode = 0;
          end
          mExp = modelNext(mExp);
        end
      end
      if (ifA.clr_err) begin
        mCnt8 = 0; mCnt2 = 0;
      end else if (err) begin
        mCnt8 = bump(mCnt8, 256);
        mCnt2 = bump(mCnt2, 4);
      end
      mLocked = (mMode == 2) ? 1 : 0;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("cyc_locked",   32'(ifA.locked),    32'(mLocked));
    checkOutput("cyc_pulse",    32'(ifA.err_pulse), 32'(mPulse));
    checkOutput("cyc_count8",   32'(ifA.err_count), 32'(mCnt8));
    checkOutput("cyc_count2",   32'(ifB.err_count), 32'(mCnt2));
    checkOutput("cyc_locked2",  32'(ifB.locked),    32'(mLocked));
  end

  task automatic applyStimulus(input logic e, input logic [3:0] d, input logic c);
    ifA.ena = e; ifA.din = d; ifA.clr_err = c;
    ifB.ena = e; ifB.din = d; ifB.clr_err = c;
    @(posedge clk);
    #1;
  endtask

  task automatic sendClean(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, 4'(seq[p]), 1'b0);
      p = (p + 1) % 15;
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    p     = 0;
    rst   = 1'b0;
    ifA.ena = 1'b0; ifA.din = '0; ifA.clr_err = 1'b0;
    ifB.ena = 1'b0; ifB.din = '0; ifB.clr_err = 1'b0;

    for (int i = 0; i < 15; i++)
      checkOutput("model_next", 32'(modelNext(seq[i])), 32'(seq[(i + 1) % 15]));

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_locked", 32'(ifA.locked), 0);
    checkOutput("rst_pulse",  32'(ifA.err_pulse), 0);
    checkOutput("rst_count",  32'(ifA.err_count), 0);
    rst = 1'b1;

    // Reseed inside CHECK, then a zero word drops back to hunting.
    applyStimulus(1'b1, 4'd5, 1'b0);
    applyStimulus(1'b1, 4'd9, 1'b0);
    applyStimulus(1'b1, 4'd3, 1'b0);
    checkOutput("reseed_nolock", 32'(ifA.locked), 0);
    applyStimulus(1'b1, 4'd0, 1'b0);

    sendClean(2);
    checkOutput("lock_after2", 32'(ifA.locked), 0);
    sendClean(1);
    checkOutput("lock_after3", 32'(ifA.locked), 1);
    sendClean(12);
    checkOutput("period_count", 32'(ifA.err_count), 0);
    checkOutput("period_locked", 32'(ifA.locked), 1);

    sendClean(4);
    applyStimulus(1'b1, 4'd7, 1'b0);
    p = (p + 1) % 15;
    checkOutput("single_pulse",  32'(ifA.err_pulse), 1);
    checkOutput("single_count",  32'(ifA.err_count), 1);
    checkOutput("single_locked", 32'(ifA.locked), 1);
    sendClean(1);
    checkOutput("fly_pulse", 32'(ifA.err_pulse), 0);
    checkOutput("fly_count", 32'(ifA.err_count), 1);

    sendClean(2);
    applyStimulus(1'b1, 4'd1, 1'b0);
    p = (p + 1) % 15;
    checkOutput("dbl1_count",  32'(ifA.err_count), 2);
    checkOutput("dbl1_locked", 32'(ifA.locked), 1);
    applyStimulus(1'b1, 4'd1, 1'b0);
    p = (p + 1) % 15;
    checkOutput("dbl2_pulse",  32'(ifA.err_pulse), 1);
    checkOutput("dbl2_count",  32'(ifA.err_count), 3);
    checkOutput("dbl2_locked", 32'(ifA.locked), 0);
    sendClean(2);
    checkOutput("relock_2", 32'(ifA.locked), 0);
    sendClean(1);
    checkOutput("relock_3", 32'(ifA.locked), 1);

    applyStimulus(1'b1, 4'd0, 1'b0);
    p = (p + 1) % 15;
    checkOutput("fourth_count8", 32'(ifA.err_count), 4);
`ifdef LFSR_CHK_ERR_SAT_EN
    checkOutput("fourth_count2", 32'(ifB.err_count), 3);
`else
    checkOutput("fourth_count2", 32'(ifB.err_count), 0);
`endif
    sendClean(1);

    applyStimulus(1'b1, 4'd2, 1'b1);
    p = (p + 1) % 15;
    checkOutput("clr_pulse",  32'(ifA.err_pulse), 1);
    checkOutput("clr_count",  32'(ifA.err_count), 0);
    checkOutput("clr_count2", 32'(ifB.err_count), 0);
    sendClean(1);

    applyStimulus(1'b0, 4'd5, 1'b0);
    checkOutput("idle_pulse", 32'(ifA.err_pulse), 0);
    sendClean(1);
    applyStimulus(1'b1, 4'd0, 1'b0);
    p = (p + 1) % 15;
    sendClean(1);
    checkOutput("pre_rst_count", 32'(ifA.err_count), 1);

    #2;
    rst = 1'b0;
    #1;
    checkOutput("async_locked", 32'(ifA.locked), 0);
    checkOutput("async_count",  32'(ifA.err_count), 0);
    #2;
    rst = 1'b1;

    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 4'd0, 1'b0);
    checkOutput("zeros_locked", 32'(ifA.locked), 0);
    applyStimulus(1'b1, 4'd8, 1'b0);
    applyStimulus(1'b1, 4'd1, 1'b0);
    checkOutput("wrap_locked1", 32'(ifA.locked), 0);
    applyStimulus(1'b1, 4'd2, 1'b0);
    checkOutput("wrap_locked2", 32'(ifA.locked), 1);

    #2;
    rst = 1'b0;
    #2;
    rst = 1'b1;
    applyStimulus(1'b1, 4'd1, 1'b0);
    applyStimulus(1'b0, 4'd7, 1'b0);
    applyStimulus(1'b1, 4'd2, 1'b0);
    applyStimulus(1'b0, 4'd7, 1'b0);
    checkOutput("toggle_nolock", 32'(ifA.locked), 0);
    applyStimulus(1'b1, 4'd4, 1'b0);
    checkOutput("toggle_lock", 32'(ifA.locked), 1);
    applyStimulus(1'b0, 4'd0, 1'b0);
    checkOutput("toggle_pulse", 32'(ifA.err_pulse), 0);
    applyStimulus(1'b1, 4'd9, 1'b0);
    checkOutput("toggle_match", 32'(ifA.err_pulse), 0);

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
